// File: rtl/nfc_pkg.sv
// Shared types and symbol patterns for the NFC envelope sequencer.
// Patterns are two half-bits ordered {1st,2nd}; a 1 selects the high envelope level.
// Pure declarations, no logic.
package nfc_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SOF    = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    EOF    = 3'd4
  } nfc_tx_state_t;

  // Frame delimiters: SOF is (lo, hi), EOF is (lo, lo)
  localparam logic [1:0] SOF_PAT = 2'b01;
  localparam logic [1:0] EOF_PAT = 2'b00;

  // Manchester symbol for one bit: 1 -> (hi, lo), 0 -> (lo, hi)
  function automatic logic [1:0] manchester(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/nfc_half_bit_timer.sv
// Half-bit timer: counts 0..HALF_BIT_CYCLES-1 while run is high, held at 0 otherwise.
// Latency: tc is high during the final count of each half-bit.
// No backpressure; run is the only control.
module nfc_half_bit_timer #(
  parameter int HALF_BIT_CYCLES = 64,
  parameter int CNT_W           = $clog2(HALF_BIT_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_BIT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  assign tc = run && (count == LAST);

  // Free-running counter while the sequencer is busy, parked at 0 when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/nfc_env_seq.sv
// Envelope sequencer: frames bytes as SOF, 8 data bits LSB-first, odd parity, EOF, Manchester-coded on env_hi.
// Latency: first SOF half-bit appears on env_hi the cycle after an idle load; env_hi changes only on half-bit boundaries.
// Backpressure: one-entry holding register, tx_ready = !hold_valid; a missing byte at a parity end ends the frame with underrun.
module nfc_env_seq
  import nfc_pkg::*;
#(
  parameter int HALF_BIT_CYCLES = 64,
  parameter int CNT_W           = $clog2(HALF_BIT_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       env_hi,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  nfc_tx_state_t state, state_n;

  logic       hold_valid;
  logic [7:0] hold_data;
  logic       hold_last;

  logic [7:0] shreg, shreg_n;
  logic       last_flag, last_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic       half, half_n;
  logic       env_n, done_n, underrun_n, consume;
  logic [1:0] cur_pat, nxt_pat;
  logic       tc;

  assign tx_ready = !hold_valid;
  assign busy     = (state != IDLE);

  nfc_half_bit_timer #(
    .HALF_BIT_CYCLES(HALF_BIT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .run(busy),
    .tc (tc)
  );

  // Holding register: accept when empty, emptied when the FSM consumes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_last  <= 1'b0;
    end else if (consume) begin
      hold_valid <= 1'b0;
    end else if (tx_valid && !hold_valid) begin
      hold_valid <= 1'b1;
      hold_data  <= tx_data;
      hold_last  <= tx_last;
    end
  end

  // Next-state, next-symbol and pulse decode
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    last_n     = last_flag;
    bit_idx_n  = bit_idx;
    half_n     = half;
    env_n      = env_hi;
    done_n     = 1'b0;
    underrun_n = 1'b0;
    consume    = 1'b0;
    nxt_pat    = EOF_PAT;

    // Symbol currently on the line, used for its second half
    case (state)
      SOF:     cur_pat = SOF_PAT;
      DATA:    cur_pat = manchester(shreg[bit_idx]);
      PARITY:  cur_pat = manchester(~^shreg);
      default: cur_pat = EOF_PAT;
    endcase

    case (state)
      IDLE: begin
        env_n  = 1'b1;
        half_n = 1'b0;
        if (hold_valid) begin
          consume = 1'b1;
          shreg_n = hold_data;
          last_n  = hold_last;
          state_n = SOF;
          env_n   = SOF_PAT[1];
        end
      end
      SOF, DATA, PARITY, EOF: begin
        if (tc && !half) begin
          half_n = 1'b1;
          env_n  = cur_pat[0];
        end else if (tc) begin
          half_n = 1'b0;
          case (state)
            SOF: begin
              state_n   = DATA;
              bit_idx_n = 3'd0;
              nxt_pat   = manchester(shreg[0]);
            end
            DATA: begin
              if (bit_idx == 3'd7) begin
                state_n = PARITY;
                nxt_pat = manchester(~^shreg);
              end else begin
                bit_idx_n = bit_idx + 3'd1;
                nxt_pat   = manchester(shreg[bit_idx_n]);
              end
            end
            PARITY: begin
              if (last_flag) begin
                state_n = EOF;
              end else if (hold_valid) begin
                consume   = 1'b1;
                shreg_n   = hold_data;
                last_n    = hold_last;
                bit_idx_n = 3'd0;
                state_n   = DATA;
                nxt_pat   = manchester(hold_data[0]);
              end else begin
                underrun_n = 1'b1;
                state_n    = EOF;
              end
            end
            default: begin
              state_n = IDLE;
              done_n  = 1'b1;
            end
          endcase
          env_n = (state == EOF) ? 1'b1 : nxt_pat[1];
        end
      end
      default: begin
        state_n = IDLE;
        env_n   = 1'b1;
      end
    endcase
  end

  // Sequencer state, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      last_flag  <= 1'b0;
      bit_idx    <= '0;
      half       <= 1'b0;
      env_hi     <= 1'b1;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      last_flag  <= last_n;
      bit_idx    <= bit_idx_n;
      half       <= half_n;
      env_hi     <= env_n;
      frame_done <= done_n;
      underrun   <= underrun_n;
    end
  end

endmodule
